// File: rtl/codec_i2s_intf.sv
// CS4272 serial audio interface: derives MCLK/SCLK/LRCLK from one free-running
// counter, deserializes I2S ADC data and serializes DAC samples onto SDin.
module codec_i2s_intf #(
  parameter int STARTUP_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] lft_out,
  input  logic signed [15:0] rht_out,
  input  logic               SDout,
  output logic               MCLK,
  output logic               SCLK,
  output logic               LRCLK,
  output logic               SDin,
  output logic               RSTn,
  output logic signed [15:0] lft_in,
  output logic signed [15:0] rht_in,
  output logic               vld
);

  localparam logic [1:0] START_LIM = 2'(STARTUP_FRAMES);

  logic [9:0]         cnt_r;
  logic [15:0]        lft_sh_r;
  logic [15:0]        rht_sh_r;
  logic [15:0]        lft_tx_r;
  logic [15:0]        rht_tx_r;
  logic [1:0]         start_cnt_r;
  logic               sdin_r;
  logic               rstn_r;
  logic               vld_r;
  logic signed [15:0] lft_in_r;
  logic signed [15:0] rht_in_r;

  logic               frame_end_s;
  logic [4:0]         slot_k_s;
  logic               rx_shift_s;
  logic [5:0]         nxt_hi_s;
  logic [15:0]        tx_word_s;
  logic               tx_bit_s;

  // Frame/slot decode and next DAC bit; nxt_hi_s is (cnt+1)[9:4] when the low nibble is 0xF
  always_comb begin
    frame_end_s = (cnt_r == 10'h3FF);
    slot_k_s    = cnt_r[8:4];
    rx_shift_s  = (cnt_r[3:0] == 4'h7) && (slot_k_s >= 5'd1) && (slot_k_s <= 5'd16);
    nxt_hi_s    = cnt_r[9:4] + 6'd1;
    tx_word_s   = nxt_hi_s[5] ? rht_tx_r : lft_tx_r;
    if ((nxt_hi_s[4:0] >= 5'd1) && (nxt_hi_s[4:0] <= 5'd16)) begin
      tx_bit_s = tx_word_s[4'(5'd16 - nxt_hi_s[4:0])];
    end else begin
      tx_bit_s = 1'b0;
    end
  end

  // Timebase and codec reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 10'd0;
      rstn_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_r + 10'd1;
      rstn_r <= 1'b1;
    end
  end

  // ADC deserializer, sampled one clk before SCLK rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_sh_r <= 16'd0;
      rht_sh_r <= 16'd0;
    end else if (rx_shift_s) begin
      if (cnt_r[9]) begin
        rht_sh_r <= {rht_sh_r[14:0], SDout};
      end else begin
        lft_sh_r <= {lft_sh_r[14:0], SDout};
      end
    end else begin
      lft_sh_r <= lft_sh_r;
      rht_sh_r <= rht_sh_r;
    end
  end

  // Frame boundary: publish received samples, latch DAC samples, startup suppression
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_in_r    <= 16'sd0;
      rht_in_r    <= 16'sd0;
      lft_tx_r    <= 16'd0;
      rht_tx_r    <= 16'd0;
      start_cnt_r <= 2'd0;
      vld_r       <= 1'b0;
    end else if (frame_end_s) begin
      lft_tx_r <= lft_out;
      rht_tx_r <= rht_out;
      if (start_cnt_r == START_LIM) begin
        lft_in_r <= lft_sh_r;
        rht_in_r <= rht_sh_r;
        vld_r    <= 1'b1;
      end else begin
        start_cnt_r <= start_cnt_r + 2'd1;
        vld_r       <= 1'b0;
      end
    end else begin
      vld_r <= 1'b0;
    end
  end

  // DAC serializer, updated as SCLK falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdin_r <= 1'b0;
    end else if (cnt_r[3:0] == 4'hF) begin
      sdin_r <= tx_bit_s;
    end else begin
      sdin_r <= sdin_r;
    end
  end

  assign MCLK   = cnt_r[1];
  assign SCLK   = cnt_r[3];
  assign LRCLK  = cnt_r[9];
  assign SDin   = sdin_r;
  assign RSTn   = rstn_r;
  assign lft_in = lft_in_r;
  assign rht_in = rht_in_r;
  assign vld    = vld_r;

endmodule

// File: tb/tb_codec_i2s_intf.sv
// Bench for codec_i2s_intf: frame table drives a codec model or SDin loopback;
// expected samples are queued per frame and checked at each vld.
module tb_codec_i2s_intf;

  localparam int STARTUP = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] lft_out = 16'sd0;
  logic signed [15:0] rht_out = 16'sd0;
  logic               SDout;
  logic               MCLK, SCLK, LRCLK, SDin, RSTn, vld;
  logic signed [15:0] lft_in, rht_in;

  codec_i2s_intf #(.STARTUP_FRAMES(STARTUP)) dut (
    .clk(clk), .rst_n(rst_n), .lft_out(lft_out), .rht_out(rht_out), .SDout(SDout),
    .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin), .RSTn(RSTn),
    .lft_in(lft_in), .rht_in(rht_in), .vld(vld)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        lp;
    logic [15:0] cl, cr, dl_e, dl_l, dr, exp_l, exp_r;
  } frame_t;
  typedef struct packed { logic [15:0] l, r; } pair_t;

  frame_t      tbl [12];
  pair_t       sb [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wrap_cnt;
  logic [9:0]  m_cnt;
  logic        loop_en = 1'b0;
  logic        codec_bit;
  logic [15:0] codec_l = 16'd0, codec_r = 16'd0;
  logic [15:0] exp_tx_l = 16'd0, exp_tx_r = 16'd0;
  logic        tx_chk = 1'b0;

  assign SDout = loop_en ? SDin : codec_bit;

  // Reference frame position
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 10'd0;
      wrap_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 10'd1;
      if (m_cnt == 10'h3FF) wrap_cnt <= wrap_cnt + 1;
    end
  end

  // Codec ADC model: I2S, MSB in slot bit 1, noise in ignored bits
  always @(negedge clk) begin
    if (m_cnt[8:4] >= 5'd1 && m_cnt[8:4] <= 5'd16)
      codec_bit <= m_cnt[9] ? codec_r[4'(5'd16 - m_cnt[8:4])] : codec_l[4'(5'd16 - m_cnt[8:4])];
    else
      codec_bit <= ^m_cnt[6:4];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cnt=%h)", name, act, exp, m_cnt);
    end
  endtask

  task automatic wait_cnt(input logic [9:0] v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != v && n < 2100);
    chk("wait_cnt", 32'(m_cnt), 32'(v));
  endtask

  task automatic start_frame(input int f);
    frame_t e = tbl[f];
    exp_tx_l = (f == 0) ? 16'd0 : lft_out;
    exp_tx_r = (f == 0) ? 16'd0 : rht_out;
    tx_chk   = 1'b1;
    loop_en  = e.lp;
    codec_l  = e.cl;
    codec_r  = e.cr;
    if (f >= STARTUP) sb.push_back({e.exp_l, e.exp_r});
    lft_out  = e.dl_e;
    rht_out  = e.dr;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      start_frame(f);
      wait_cnt(10'h100);
      lft_out = tbl[f].dl_l;
      wait_cnt(10'h000);
    end
    exp_tx_l = lft_out;
    exp_tx_r = rht_out;
  endtask

  // Per-cycle monitor: clock dividers, vld timing, scoreboard, SDin bits
  initial begin
    int   last_cyc = 0;
    bit   have_last = 0;
    logic exp_vld, exp_bit;
    pair_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        have_last = 0;
        continue;
      end
      chk("clk_div", 32'({MCLK, SCLK, LRCLK}), 32'({m_cnt[1], m_cnt[3], m_cnt[9]}));
      exp_vld = (m_cnt == 10'h000) && (wrap_cnt > STARTUP);
      chk("vld", 32'(vld), 32'(exp_vld));
      if (vld) begin
        if (have_last) chk("vld_spacing", 32'(cyc - last_cyc), 32'd1024);
        have_last = 1;
        last_cyc  = cyc;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL vld_unexpected: got vld with empty scoreboard (cnt=%h)", m_cnt);
        end else begin
          e = sb.pop_front();
          chk("lft_in", 32'($unsigned(lft_in)), 32'(e.l));
          chk("rht_in", 32'($unsigned(rht_in)), 32'(e.r));
        end
      end
      if (tx_chk && m_cnt[3:0] == 4'h8) begin
        if (m_cnt[8:4] >= 5'd1 && m_cnt[8:4] <= 5'd16)
          exp_bit = m_cnt[9] ? exp_tx_r[4'(5'd16 - m_cnt[8:4])] : exp_tx_l[4'(5'd16 - m_cnt[8:4])];
        else
          exp_bit = 1'b0;
        chk("sdin", 32'(SDin), 32'(exp_bit));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //         lp    cl        cr        dl_e      dl_l      dr        exp_l     exp_r
    tbl[0]  = '{1'b0, 16'hA5C3, 16'h0F0F, 16'h0000, 16'h8001, 16'h7FFE, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 16'hA5C3, 16'h0F0F, 16'h1111, 16'h8001, 16'h7FFE, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 16'hA5C3, 16'h0F0F, 16'h8001, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h0F0F};
    tbl[3]  = '{1'b1, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    tbl[4]  = '{1'b1, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    tbl[5]  = '{1'b1, 16'h0000, 16'h0000, 16'h5555, 16'h1234, 16'h7FFE, 16'h8001, 16'h7FFE};
    tbl[6]  = '{1'b1, 16'h0000, 16'h0000, 16'h1234, 16'h4321, 16'h0001, 16'h1234, 16'h7FFE};
    tbl[7]  = '{1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h4321, 16'h8000, 16'h4321, 16'h0001};
    tbl[8]  = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h00FF, 16'hFF00, 16'h0000, 16'hFFFF};
    tbl[9]  = '{1'b0, 16'h7FFF, 16'h8000, 16'h0000, 16'h00FF, 16'hFF00, 16'h7FFF, 16'h8000};
    tbl[10] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'hFF00};
    tbl[11] = '{1'b0, 16'h1357, 16'h9BDF, 16'h0000, 16'h0000, 16'h0000, 16'h1357, 16'h9BDF};

    repeat (20) @(negedge clk);
    chk("reset_outputs", 32'({MCLK, SCLK, LRCLK, SDin, RSTn, vld}), 32'd0);
    chk("reset_samples", {lft_in, rht_in}, 32'd0);
    rst_n = 1'b1;
    chk("rstn_held", 32'(RSTn), 32'd0);
    @(negedge clk);
    chk("rstn_rise", 32'(RSTn), 32'd1);
    run_frames(12);

    // Reset in the middle of a left slot
    wait_cnt(10'h180);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    rst_n  = 1'b0;
    tx_chk = 1'b0;
    sb.delete();
    #1;
    chk("midreset_outputs", 32'({MCLK, SCLK, LRCLK, SDin, RSTn, vld}), 32'd0);
    chk("midreset_samples", {lft_in, rht_in}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstn_rise2", 32'(RSTn), 32'd1);
    run_frames(5);
    repeat (4) @(negedge clk);
    chk("sb_drain2", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
